// File: rtl/keypad_pkg.sv
// Shared types, matrix geometry and keycode map for the calculator keypad scanner.
package keypad_pkg;

    localparam int NCOLS      = 4;
    localparam int NROWS      = 6;
    localparam int NKEYS      = NCOLS * NROWS;
    localparam int KEY_UNUSED = 23;

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        EMIT,
        HELD
    } kp_state_e;

    typedef enum logic [1:0] {
        FR_NONE,
        FR_SINGLE,
        FR_MULTI
    } frame_kind_e;

    typedef struct packed {
        frame_kind_e kind;
        logic [4:0]  idx;
    } frame_cls_t;

    localparam logic       KC_DIGIT = 1'b1;
    localparam logic [4:0] KC_ADD   = 5'b01011;
    localparam logic [4:0] KC_SUB   = 5'b01010;
    localparam logic [4:0] KC_MUL   = 5'b01001;
    localparam logic [4:0] KC_EQ    = 5'b00100;
    localparam logic [4:0] KC_CLR   = 5'b00010;
    localparam logic [4:0] KC_MS    = 5'b00001;
    localparam logic [4:0] KC_MR    = 5'b01100;

    function automatic logic [4:0] key_map(input logic [4:0] idx);
        logic [4:0] kc;
        kc = '0;
        if (idx < 5'd16) begin
            kc = {KC_DIGIT, idx[3:0]};
        end else begin
            case (idx)
                5'd16:   kc = KC_ADD;
                5'd17:   kc = KC_SUB;
                5'd18:   kc = KC_MUL;
                5'd19:   kc = KC_EQ;
                5'd20:   kc = KC_CLR;
                5'd21:   kc = KC_MS;
                5'd22:   kc = KC_MR;
                default: kc = '0;
            endcase
        end
        return kc;
    endfunction

    // The unused position counts toward MULTI but never forms a SINGLE on its own.
    function automatic frame_cls_t classify(input logic [NKEYS-1:0] frame);
        frame_cls_t cls;
        logic [4:0] cnt;
        cls.kind = FR_NONE;
        cls.idx  = '0;
        cnt      = '0;
        for (int i = 0; i < NKEYS; i++) begin
            if (frame[i]) begin
                cnt     = cnt + 5'd1;
                cls.idx = 5'(i);
            end
        end
        if (cnt >= 5'd2) begin
            cls.kind = FR_MULTI;
        end else if (cnt == 5'd1 && !frame[KEY_UNUSED]) begin
            cls.kind = FR_SINGLE;
        end
        return cls;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for asynchronous, pulled-up keypad row inputs.
module keypad_sync #(
    parameter int               WIDTH = 1,
    parameter logic [WIDTH-1:0] INIT  = '1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [1:0][WIDTH-1:0] stage;

    always_ff @(posedge clock) begin
        if (reset) begin
            stage <= {2{INIT}};
        end else begin
            stage <= {stage[0], d};
        end
    end

    assign q = stage[1];

endmodule

// File: rtl/keypad_scanner.sv
// Column-multiplexed 4x6 keypad scanner: frame classification, debounce,
// multi-key rejection and release detection, one new_key pulse per press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_FRAMES = 3,
    parameter int REL_FRAMES = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NROWS-1:0] row_n,
    output logic [NCOLS-1:0] col_n,
    output logic             new_key,
    output logic [4:0]       keycode
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEB_FRAMES + 1);
    localparam int REL_W = $clog2(REL_FRAMES + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_FRAMES - 1);
    localparam logic [REL_W-1:0] REL_LAST = REL_W'(REL_FRAMES - 1);

    logic [NROWS-1:0] row_s;
    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       col;
    logic             sample;
    logic             frame_eval;
    logic [NKEYS-1:0] frame_acc;
    logic [NKEYS-1:0] frame_now;
    frame_cls_t       cls;

    kp_state_e        state, state_nx;
    logic [4:0]       cand, cand_nx;
    logic [DEB_W-1:0] deb, deb_nx;
    logic [REL_W-1:0] rel, rel_nx;

    keypad_sync #(
        .WIDTH (NROWS)
    ) u_row_sync (
        .clock (clock),
        .reset (reset),
        .d     (row_n),
        .q     (row_s)
    );

    assign sample     = (div_cnt == DIV_LAST);
    assign frame_eval = sample && (col == 2'(NCOLS - 1));
    assign col_n      = ~(NCOLS'(1) << col);

    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt   <= '0;
            col       <= '0;
            frame_acc <= '0;
        end else if (sample) begin
            div_cnt   <= '0;
            col       <= col + 2'd1;
            frame_acc <= frame_eval ? '0 : frame_now;
        end else begin
            div_cnt   <= div_cnt + DIV_W'(1);
        end
    end

    // Frame so far with the current column's synchronized rows merged in;
    // on the column-3 sample this is the complete frame.
    always_comb begin
        frame_now = frame_acc;
        for (int r = 0; r < NROWS; r++) begin
            for (int c = 0; c < NCOLS; c++) begin
                if (2'(c) == col) begin
                    frame_now[r*NCOLS + c] = ~row_s[r];
                end
            end
        end
    end

    assign cls = classify(frame_now);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cand  <= '0;
            deb   <= '0;
            rel   <= '0;
        end else begin
            state <= state_nx;
            cand  <= cand_nx;
            deb   <= deb_nx;
            rel   <= rel_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        deb_nx   = deb;
        rel_nx   = rel;
        case (state)
            IDLE: begin
                if (frame_eval && cls.kind == FR_SINGLE) begin
                    cand_nx  = cls.idx;
                    deb_nx   = DEB_W'(1);
                    state_nx = (DEB_FRAMES == 1) ? EMIT : DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (frame_eval) begin
                    if (cls.kind != FR_SINGLE) begin
                        state_nx = IDLE;
                    end else if (cls.idx != cand) begin
                        cand_nx = cls.idx;
                        deb_nx  = DEB_W'(1);
                    end else begin
                        deb_nx = deb + DEB_W'(1);
                        if (deb == DEB_LAST) begin
                            state_nx = EMIT;
                        end
                    end
                end
            end
            EMIT: begin
                state_nx = HELD;
                rel_nx   = '0;
            end
            HELD: begin
                if (frame_eval) begin
                    if (cls.kind == FR_NONE) begin
                        rel_nx = rel + REL_W'(1);
                        if (rel == REL_LAST) begin
                            state_nx = IDLE;
                        end
                    end else begin
                        rel_nx = '0;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are loaded on entry to EMIT so the pulse coincides with the EMIT cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            new_key <= 1'b0;
            keycode <= '0;
        end else begin
            new_key <= (state_nx == EMIT);
            if (state_nx == EMIT) begin
                keycode <= key_map(cand_nx);
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a combinational key-matrix model.
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int FRAME    = 4 * SCAN_DIV;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] row_n;
    logic [3:0] col_n;
    logic       new_key;
    logic [4:0] keycode;

    logic [23:0] keys = '0;
    logic [4:0]  pulse_kc;
    logic [3:0]  exp_col;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          npulse;
    int          pulse_cyc;
    bit          chk_cols = 1'b0;

    always #5 clock = ~clock;

    always_comb begin
        row_n = '1;
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4 + c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    keypad_scanner #(
        .SCAN_DIV   (SCAN_DIV),
        .DEB_FRAMES (3),
        .REL_FRAMES (3)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .row_n   (row_n),
        .col_n   (col_n),
        .new_key (new_key),
        .keycode (keycode)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Called at a negedge; holds reset for n edges, checks reset state, then releases.
    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) @(posedge clock);
        @(negedge clock);
        chk("rst_col_n", 32'(col_n), 32'h0e);
        chk("rst_new_key", 32'(new_key), 32'h0);
        chk("rst_keycode", 32'(keycode), 32'h0);
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic run_frames(input int n);
        npulse    = 0;
        pulse_cyc = -1;
        repeat (n * FRAME) begin
            if (new_key) begin
                npulse++;
                pulse_cyc = cyc;
                pulse_kc  = keycode;
            end
            if (chk_cols && cyc < FRAME) begin
                exp_col = ~(4'b0001 << (cyc / SCAN_DIV));
                chk("col_rot", 32'(col_n), 32'(exp_col));
            end
            @(posedge clock);
            @(negedge clock);
            cyc++;
        end
    endtask

    initial begin
        @(negedge clock);

        // Digit 7 held 6 frames
        keys = 24'(1) << 7;
        do_reset(3);
        run_frames(6);
        chk("d7_npulse", npulse, 1);
        chk("d7_cycle", pulse_cyc, 48);
        chk("d7_code", 32'(pulse_kc), 32'h17);
        chk("d7_hold_code", 32'(keycode), 32'h17);

        // Key 19: too short, then long enough
        keys = 24'(1) << 19;
        do_reset(2);
        run_frames(2);
        keys = '0;
        run_frames(4);
        chk("eq_short_npulse", npulse, 0);
        keys = 24'(1) << 19;
        run_frames(4);
        chk("eq_npulse", npulse, 1);
        chk("eq_cycle", pulse_cyc, 144);
        chk("eq_code", 32'(pulse_kc), 32'h04);

        // Keys 0 and 5 together, then release 5
        keys = (24'(1) << 0) | (24'(1) << 5);
        do_reset(2);
        run_frames(6);
        chk("multi_npulse", npulse, 0);
        keys = 24'(1) << 0;
        run_frames(4);
        chk("multi_rel_npulse", npulse, 1);
        chk("multi_rel_cycle", pulse_cyc, 144);
        chk("multi_rel_code", 32'(pulse_kc), 32'h10);

        // Key 16: short release does not re-arm, full release does
        keys = 24'(1) << 16;
        do_reset(2);
        run_frames(4);
        chk("add1_npulse", npulse, 1);
        chk("add1_code", 32'(pulse_kc), 32'h0b);
        keys = '0;
        run_frames(2);
        keys = 24'(1) << 16;
        run_frames(4);
        chk("add_short_rel_npulse", npulse, 0);
        keys = '0;
        run_frames(3);
        chk("add_rel_npulse", npulse, 0);
        keys = 24'(1) << 16;
        run_frames(4);
        chk("add2_npulse", npulse, 1);
        chk("add2_cycle", pulse_cyc, 256);
        chk("add2_code", 32'(pulse_kc), 32'h0b);

        // Reset during debounce of key 22
        keys = 24'(1) << 22;
        do_reset(2);
        run_frames(2);
        repeat (3) begin
            @(posedge clock);
            @(negedge clock);
        end
        chk("mr_pre_npulse", npulse, 0);
        do_reset(1);
        run_frames(4);
        chk("mr_npulse", npulse, 1);
        chk("mr_cycle", pulse_cyc, 48);
        chk("mr_code", 32'(pulse_kc), 32'h0c);

        // Unused index 23 alone, plus column rotation
        keys = 24'(1) << 23;
        do_reset(2);
        chk_cols = 1'b1;
        run_frames(6);
        chk_cols = 1'b0;
        chk("k23_npulse", npulse, 0);
        chk("k23_code", 32'(keycode), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
